// File: rtl/display_arbiter_if.sv
// Bundle between the lock controller (master) and the display arbiter (slave).
// The controller raises display requests; the arbiter returns the owner and scan outputs.
interface display_arbiter_if;
    logic       entry_req;
    logic [2:0] entry_len;
    logic       err_req;
    logic [3:0] err_count;
    logic       lock_req;
    logic [7:0] lock_secs;
    logic       msg_req;
    logic [1:0] msg_code;
    logic [2:0] grant;
    logic [2:0] scan_idx;
    logic [7:0] wei;
    logic [3:0] digit;

    modport master (
        output entry_req, entry_len, err_req, err_count,
        output lock_req, lock_secs, msg_req, msg_code,
        input  grant, scan_idx, wei, digit
    );

    modport slave (
        input  entry_req, entry_len, err_req, err_count,
        input  lock_req, lock_secs, msg_req, msg_code,
        output grant, scan_idx, wei, digit
    );
endinterface

// File: rtl/display_arbiter.sv
// Display arbiter: grants the 8-digit multiplexed display to one status source
// by fixed priority (LOCK > ERR/MSG > ENTRY > IDLE), times one-shot ERR/MSG
// owners and runs the digit scan. digit/wei are registered and are computed
// from next-cycle owner and slot so an owner change shows on the same edge.
module display_arbiter #(
    parameter int SCAN_DIV = 50000,
    parameter int HOLD_CYC = 100000000
) (
    input logic              clk,
    input logic              reset,
    display_arbiter_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int TW = $clog2(HOLD_CYC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_ERR   = 3'd2,
        S_MSG   = 3'd3,
        S_LOCK  = 3'd4
    } owner_t;

    owner_t        owner_reg, owner_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [3:0]    err_cnt_reg, err_cnt_next;
    logic [1:0]    msg_code_reg, msg_code_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [2:0]    scan_idx_reg, scan_idx_next;
    logic [7:0]    wei_reg;
    logic [3:0]    digit_reg, digit_next;
    logic [31:0]   slot_glyph;
    logic [2:0]    len_clamp;
    logic [7:0]    secs_clamp;
    logic [3:0]    lock_tens, lock_ones, err_tens, err_ones;

    // Owner state, hold timer and latched ERR count / MSG code.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg    <= S_IDLE;
            timer_reg    <= '0;
            err_cnt_reg  <= '0;
            msg_code_reg <= '0;
        end else begin
            owner_reg    <= owner_next;
            timer_reg    <= timer_next;
            err_cnt_reg  <= err_cnt_next;
            msg_code_reg <= msg_code_next;
        end
    end

    // Owner arbitration: lockout overrides all, ERR beats MSG on a tie, and
    // ERR/MSG owners release only when the hold timer has run down to zero.
    always_comb begin
        owner_next    = owner_reg;
        timer_next    = timer_reg;
        err_cnt_next  = err_cnt_reg;
        msg_code_next = msg_code_reg;
        if (bus.lock_req) begin
            owner_next = S_LOCK;
            timer_next = '0;
        end else if (bus.err_req) begin
            owner_next   = S_ERR;
            err_cnt_next = bus.err_count;
            timer_next   = HOLD_LOAD;
        end else if (bus.msg_req) begin
            owner_next    = S_MSG;
            msg_code_next = bus.msg_code;
            timer_next    = HOLD_LOAD;
        end else begin
            case (owner_reg)
                S_ERR, S_MSG: begin
                    if (timer_reg == '0)
                        owner_next = bus.entry_req ? S_ENTRY : S_IDLE;
                    else
                        timer_next = timer_reg - 1'b1;
                end
                default: owner_next = bus.entry_req ? S_ENTRY : S_IDLE;
            endcase
        end
    end

    // Scan prescaler: advance to the next slot once every SCAN_DIV cycles.
    always_comb begin
        presc_next    = presc_reg + 1'b1;
        scan_idx_next = scan_idx_reg;
        if (presc_reg == PRESC_LAST) begin
            presc_next    = '0;
            scan_idx_next = scan_idx_reg + 3'd1;
        end
    end

    // Input clamping and binary-to-BCD for the two numeric fields.
    always_comb begin
        len_clamp  = (bus.entry_len > 3'd4) ? 3'd4 : bus.entry_len;
        secs_clamp = (bus.lock_secs > 8'd99) ? 8'd99 : bus.lock_secs;
        lock_tens  = 4'(secs_clamp / 8'd10);
        lock_ones  = 4'(secs_clamp % 8'd10);
        err_tens   = (err_cnt_next >= 4'd10) ? 4'd1 : 4'd0;
        err_ones   = (err_cnt_next >= 4'd10) ? (err_cnt_next - 4'd10) : err_cnt_next;
    end

    // One glyph per slot for the upcoming owner; the scan picks one below.
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
        localparam logic [2:0] SLOT = 3'(gi);
        logic [3:0] glyph;

        // Slot content table for this slot position.
        always_comb begin
            glyph = 4'hF;
            case (owner_next)
                S_ENTRY: if (SLOT < len_clamp) glyph = 4'hA;
                S_ERR: begin
                    if (gi == 7)      glyph = 4'hB;
                    else if (gi == 1) glyph = err_tens;
                    else if (gi == 0) glyph = err_ones;
                end
                S_MSG: begin
                    if (gi == 7)      glyph = 4'hD;
                    else if (gi == 0) glyph = {2'b00, msg_code_next};
                end
                S_LOCK: begin
                    if (gi == 7)      glyph = 4'hC;
                    else if (gi == 1) glyph = lock_tens;
                    else if (gi == 0) glyph = lock_ones;
                end
                default: glyph = 4'hF;
            endcase
        end

        assign slot_glyph[gi*4 +: 4] = glyph;
    end

    assign digit_next = slot_glyph[{scan_idx_next, 2'b00} +: 4];

    // Scan counters and registered display outputs; digit refreshes every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg    <= '0;
            scan_idx_reg <= '0;
            wei_reg      <= 8'hFE;
            digit_reg    <= 4'hF;
        end else begin
            presc_reg    <= presc_next;
            scan_idx_reg <= scan_idx_next;
            wei_reg      <= ~(8'd1 << scan_idx_next);
            digit_reg    <= digit_next;
        end
    end

    assign bus.grant    = owner_reg;
    assign bus.scan_idx = scan_idx_reg;
    assign bus.wei      = wei_reg;
    assign bus.digit    = digit_reg;
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with SCAN_DIV=4, HOLD_CYC=20.
// The scan position is modelled from a cycle count since the last reset edge.
module tb_display_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc  = 0;

    display_arbiter_if ifc ();

    display_arbiter #(.SCAN_DIV(4), .HOLD_CYC(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Cycles since the last reset edge; drives the expected scan position.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs now; slots holds nibble i = expected glyph of slot i.
    task automatic check_now(input string tag, input logic [2:0] g, input logic [31:0] slots);
        int         idx;
        logic [7:0] w;
        logic [3:0] d;
        idx = (cyc / 4) % 8;
        w   = ~(8'd1 << idx);
        d   = slots[idx*4 +: 4];
        chk({tag, ".grant"}, ifc.grant, g);
        chk({tag, ".scan"}, ifc.scan_idx, idx);
        chk({tag, ".wei"}, ifc.wei, w);
        chk({tag, ".digit"}, ifc.digit, d);
    endtask

    task automatic sweep(input string tag, input int n, input logic [2:0] g, input logic [31:0] slots);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_now(tag, g, slots);
        end
    endtask

    // Wait (bounded) until the cycle count sits at phase p of the 32-cycle frame.
    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while ((cyc % 32) != p && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("wait_phase", cyc % 32, p);
    endtask

    initial begin
        ifc.entry_req = 0; ifc.entry_len = 0; ifc.err_req = 0; ifc.err_count = 0;
        ifc.lock_req = 0;  ifc.lock_secs = 0; ifc.msg_req = 0; ifc.msg_code = 0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_now("reset", 3'd0, 32'hFFFF_FFFF);
        reset = 0;
        sweep("idle", 40, 3'd0, 32'hFFFF_FFFF);

        // PIN entry progress, including the clamp of entry_len
        ifc.entry_req = 1; ifc.entry_len = 3;
        sweep("entry3", 32, 3'd1, 32'hFFFF_FAAA);
        ifc.entry_len = 6;
        sweep("entry6", 32, 3'd1, 32'hFFFF_AAAA);

        // ERR holds exactly 20 cycles, then back to ENTRY
        wait_phase(25);
        ifc.err_req = 1; ifc.err_count = 12;
        @(negedge clk);
        ifc.err_req = 0;
        check_now("err12", 3'd2, 32'hBFFF_FF12);
        sweep("err12", 19, 3'd2, 32'hBFFF_FF12);
        sweep("err_end", 4, 3'd1, 32'hFFFF_AAAA);

        // MSG preempts ERR at its 5th cycle and restarts the timer
        ifc.err_req = 1; ifc.err_count = 7;
        @(negedge clk);
        ifc.err_req = 0;
        check_now("err7", 3'd2, 32'hBFFF_FF07);
        sweep("err7", 4, 3'd2, 32'hBFFF_FF07);
        ifc.msg_req = 1; ifc.msg_code = 2;
        @(negedge clk);
        ifc.msg_req = 0;
        check_now("msg2", 3'd3, 32'hDFFF_FFF2);
        sweep("msg2", 19, 3'd3, 32'hDFFF_FFF2);
        sweep("msg_end", 3, 3'd1, 32'hFFFF_AAAA);

        // Same-cycle ERR and MSG: ERR wins
        ifc.err_req = 1; ifc.err_count = 3; ifc.msg_req = 1; ifc.msg_code = 1;
        @(negedge clk);
        ifc.err_req = 0; ifc.msg_req = 0;
        check_now("tie", 3'd2, 32'hBFFF_FF03);
        sweep("tie", 2, 3'd2, 32'hBFFF_FF03);

        // Lockout during MSG; clamp to 99; ERR ignored; live seconds
        ifc.msg_req = 1; ifc.msg_code = 0;
        @(negedge clk);
        ifc.msg_req = 0;
        check_now("msg0", 3'd3, 32'hDFFF_FFF0);
        ifc.lock_req = 1; ifc.lock_secs = 150;
        sweep("lock150", 3, 3'd4, 32'hCFFF_FF99);
        ifc.err_req = 1; ifc.err_count = 5;
        @(negedge clk);
        ifc.err_req = 0;
        check_now("lock_err", 3'd4, 32'hCFFF_FF99);
        sweep("lock_err", 10, 3'd4, 32'hCFFF_FF99);
        ifc.lock_secs = 42;
        sweep("lock42", 32, 3'd4, 32'hCFFF_FF42);
        ifc.lock_req = 0; ifc.entry_req = 0;
        sweep("unlock", 30, 3'd0, 32'hFFFF_FFFF);

        // Entry with zero digits shows all blank
        ifc.entry_req = 1; ifc.entry_len = 0;
        sweep("entry0", 8, 3'd1, 32'hFFFF_FFFF);
        ifc.entry_req = 0;
        sweep("entry_off", 2, 3'd0, 32'hFFFF_FFFF);

        // Reset in the middle of ERR clears everything, no return to ERR
        ifc.err_req = 1; ifc.err_count = 9;
        @(negedge clk);
        ifc.err_req = 0;
        check_now("err9", 3'd2, 32'hBFFF_FF09);
        sweep("err9", 3, 3'd2, 32'hBFFF_FF09);
        reset = 1;
        @(negedge clk);
        check_now("rst_mid", 3'd0, 32'hFFFF_FFFF);
        reset = 0;
        sweep("post_rst", 30, 3'd0, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 8-digit multiplexed seven-segment display among the lock's status sources: PIN entry progress, wrong-code events, lockout countdown, and one-shot action messages (OPEN/SAVE/CHANGE/SET). Sits between the main lock controller and the segment decoder. It grants the display to one owner by fixed priority, holds one-shot messages for a programmable time and runs the digit scan. Outputs are a digit-select strobe and a 4-bit glyph code per scan slot.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles per scan slot (>=2)
- HOLD_CYC, 100000000: clock cycles an ERR/MSG owner holds the display (>=2)

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- entry_req  in  1  level: PIN entry in progress
- entry_len  in  3  digits entered, 0..4; values >4 treated as 4
- err_req  in  1  one-cycle pulse: wrong code event
- err_count  in  4  wrong-attempt count, 0..15; sampled on err_req
- lock_req  in  1  level: lockout active
- lock_secs  in  8  lockout seconds remaining; values >99 shown as 99
- msg_req  in  1  one-cycle pulse: action message
- msg_code  in  2  0=OPEN, 1=SAVE, 2=CHANGE, 3=SET; sampled on msg_req
- grant  out  3  current owner: 0 IDLE, 1 ENTRY, 2 ERR, 3 MSG, 4 LOCK
- scan_idx  out  3  active slot, 0 = rightmost
- wei  out  8  digit select, active-low, one-hot-zero
- digit  out  4  glyph: 0-9 decimal, A '-', B 'E', C 'L', D 'o', F blank

## Operation
- Owner FSM states: IDLE, ENTRY, ERR, MSG, LOCK. Priority: LOCK > ERR/MSG > ENTRY > IDLE.
- lock_req=1 forces LOCK from any state. It clears the hold timer and drops any ERR/MSG in progress. err_req/msg_req pulses are ignored while lock_req=1.
- err_req: latches err_count and enters ERR. msg_req: latches msg_code and enters MSG. Both load the hold timer with HOLD_CYC-1.
- A new err_req/msg_req during ERR or MSG preempts the current one: it re-latches, switches state and restarts the timer. If err_req and msg_req arrive in the same cycle, err_req wins and msg_req is dropped.
- Timer reaches 0 in ERR/MSG: the FSM leaves for LOCK if lock_req, else ENTRY if entry_req, else IDLE.
- ENTRY and IDLE follow entry_req level directly, one cycle late.
- lock_req deasserting: the FSM goes to ENTRY if entry_req, else IDLE.
- Slot content by owner (slot i, i=0 rightmost); every slot not listed shows F:
  - IDLE: all blank.
  - ENTRY: slots 0..entry_len-1 show A ('-'). Digits are never shown in clear.
  - ERR: slot 7 = B, slot 1 = tens of latched count, slot 0 = ones.
  - MSG: slot 7 = D, slot 0 = latched msg_code.
  - LOCK: slot 7 = C, slot 1 = tens of min(lock_secs,99), slot 0 = ones. lock_secs is read live, not latched.
- Binary-to-BCD conversion is combinational, ranges 0..15 and 0..99.

## Timing
- Reset values: grant=0, scan_idx=0, wei=8'hFE, digit=F. Hold timer, scan prescaler and latched count/code are all 0.
- Reset asserted mid-message or mid-lock returns all state to reset values on the next edge. There is no pending-request memory.
- Request sampled at edge N: grant changes at edge N+1. digit reflects the new owner at edge N+1 for the current slot.
- Scan prescaler counts 0..SCAN_DIV-1. On wrap, scan_idx increments mod 8 (7 wraps to 0), and wei/digit update in the same edge.
- Between wraps, digit still re-evaluates every cycle for the current slot, so owner changes appear without waiting for a slot boundary.
- wei = ~(1<<scan_idx), registered. Exactly one bit is low at all times after reset.
- ERR/MSG hold duration: grant leaves ERR/MSG exactly HOLD_CYC cycles after the grant change.
- The scan never stalls across owner changes.

## Test plan
- Use SCAN_DIV=4, HOLD_CYC=20. Reset, then idle 40 cycles -> grant=0, digit=F every slot, wei steps FE,FD,FB,…,7F,FE every 4 cycles.
- entry_req=1, entry_len=3 -> grant=1 next cycle. Slots 0-2 show A, slots 3-7 show F. entry_len=6 -> slots 0-3 show A.
- err_req pulse with err_count=12, entry_req=1 -> grant=2 for exactly 20 cycles. Slots 7/1/0 = B/1/2. Then grant=1.
- msg_req (code 2) at cycle 5 of ERR -> grant=3, slot 0 = 2, timer restarted to 20. Same-cycle err_req+msg_req -> grant=2.
- lock_req=1 during MSG with lock_secs=150 -> grant=4, slots 7/1/0 = C/9/9. err_req during lock is ignored. lock_req=0, entry_req=0 -> grant=0.
- reset pulse mid-ERR -> next edge grant=0, wei=FE, digit=F. After reset release, no return to ERR.
